// File: rtl/i8088_bus_pkg.sv
// Shared types for the 8288-style bus controller: CPU status codes, FSM states,
// the registered output bundle and small cycle-classification helpers.
package i8088_bus_pkg;

    typedef enum logic [2:0] {
        ST_INTA    = 3'b000,
        ST_IOR     = 3'b001,
        ST_IOW     = 3'b010,
        ST_HALT    = 3'b011,
        ST_CODE    = 3'b100,
        ST_MEMR    = 3'b101,
        ST_MEMW    = 3'b110,
        ST_PASSIVE = 3'b111
    } status_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        TW   = 3'd3,
        T4   = 3'd4,
        HLT  = 3'd5
    } bus_state_e;

    localparam int unsigned MAX_WAIT = 32'd7;

    typedef struct packed {
        logic [19:0] addr;
        logic        ale;
        logic        mrdc_n;
        logic        mwtc_n;
        logic        amwc_n;
        logic        iorc_n;
        logic        iowc_n;
        logic        aiowc_n;
        logic        inta_n;
        logic        dt_r_n;
        logic        den;
        logic        busy;
    } ctrl_out_t;

    // Quiescent bus outputs; the latched address is carried through unchanged.
    function automatic ctrl_out_t idle_out(input logic [19:0] addr);
        ctrl_out_t o;
        o.addr    = addr;
        o.ale     = 1'b0;
        o.mrdc_n  = 1'b1;
        o.mwtc_n  = 1'b1;
        o.amwc_n  = 1'b1;
        o.iorc_n  = 1'b1;
        o.iowc_n  = 1'b1;
        o.aiowc_n = 1'b1;
        o.inta_n  = 1'b1;
        o.dt_r_n  = 1'b1;
        o.den     = 1'b0;
        o.busy    = 1'b0;
        return o;
    endfunction

    function automatic logic is_read(input status_e st);
        case (st)
            ST_INTA, ST_IOR, ST_CODE, ST_MEMR: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

    function automatic logic is_io(input status_e st);
        case (st)
            ST_IOR, ST_IOW: return 1'b1;
            default:        return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] wait_cnt(input int unsigned w);
        if (w > MAX_WAIT) begin
            return 3'd7;
        end else begin
            return 3'(w);
        end
    endfunction

endpackage

// File: rtl/i8288_bus_ctrl_if.sv
// CPU-side status/address/ready inputs and the controller's command outputs.
interface i8288_bus_ctrl_if;

    logic [2:0]  S2_S0_IN;
    logic [19:0] AD_IN;
    logic        READY_IN;
    logic [19:0] ADDR;
    logic        ALE;
    logic        MRDC_N;
    logic        MWTC_N;
    logic        AMWC_N;
    logic        IORC_N;
    logic        IOWC_N;
    logic        AIOWC_N;
    logic        INTA_N;
    logic        DT_R_N;
    logic        DEN;
    logic        READY_OUT;
    logic        BUSY;

    modport master (
        output S2_S0_IN, AD_IN, READY_IN,
        input  ADDR, ALE, MRDC_N, MWTC_N, AMWC_N, IORC_N, IOWC_N, AIOWC_N,
               INTA_N, DT_R_N, DEN, READY_OUT, BUSY
    );

    modport slave (
        input  S2_S0_IN, AD_IN, READY_IN,
        output ADDR, ALE, MRDC_N, MWTC_N, AMWC_N, IORC_N, IOWC_N, AIOWC_N,
               INTA_N, DT_R_N, DEN, READY_OUT, BUSY
    );

endinterface

// File: rtl/ready_sync.sv
// READY_IN synchronizer and wait-state counter. The output flop is also the
// second synchronizer stage, so READY_OUT follows READY_IN two edges later.
module ready_sync
    import i8088_bus_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ready_in,
    input  logic       load,
    input  logic [2:0] load_val,
    input  logic       dec,
    output logic       ready_out
);

    logic       sync1_r;
    logic       ready_r;
    logic [2:0] cnt_r;
    logic [2:0] cnt_nxt_s;

    // Counter next value: load on T2 entry, saturating decrement while in TW
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (load) begin
            cnt_nxt_s = load_val;
        end else if (dec && (cnt_r != 3'd0)) begin
            cnt_nxt_s = cnt_r - 3'd1;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Synchronizer, counter and ready registers; ready is gated with the
    // counter value being registered on the same edge so that N wait states
    // add exactly N TW cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            ready_r <= 1'b0;
            cnt_r   <= 3'd0;
        end else begin
            sync1_r <= ready_in;
            ready_r <= sync1_r & (cnt_nxt_s == 3'd0);
            cnt_r   <= cnt_nxt_s;
        end
    end

    assign ready_out = ready_r;

endmodule

// File: rtl/i8288_bus_ctrl.sv
// 8288-style bus controller: decodes CPU status into ALE, commands and
// transceiver control, with programmable wait states and ready handshake.
module i8288_bus_ctrl
    import i8088_bus_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 32'd0,
    parameter int unsigned IO_WAIT  = 32'd1
)
(
    input  logic           CLK,
    input  logic           RESET_N,
    i8288_bus_ctrl_if.slave bus
);

    localparam logic [2:0] MEM_WAIT_C = wait_cnt(MEM_WAIT);
    localparam logic [2:0] IO_WAIT_C  = wait_cnt(IO_WAIT);

    bus_state_e state_r;
    bus_state_e nxt_state_s;
    status_e    cyc_r;
    status_e    nxt_cyc_s;
    status_e    status_s;
    ctrl_out_t  out_r;
    ctrl_out_t  nxt_out_s;
    logic       load_s;
    logic [2:0] load_val_s;
    logic       dec_s;
    logic       ready_s;

    assign status_s = status_e'(bus.S2_S0_IN);
    assign dec_s    = (state_r == TW);

    ready_sync u_ready_sync (
        .clk       (CLK),
        .rst_n     (RESET_N),
        .ready_in  (bus.READY_IN),
        .load      (load_s),
        .load_val  (load_val_s),
        .dec       (dec_s),
        .ready_out (ready_s)
    );

    // Next-state and next-output decode; the cycle type is only sampled in IDLE/T4
    always_comb begin
        nxt_state_s   = state_r;
        nxt_out_s     = out_r;
        nxt_cyc_s     = cyc_r;
        load_s        = 1'b0;
        load_val_s    = 3'd0;
        nxt_out_s.ale = 1'b0;
        case (state_r)
            IDLE, T4: begin
                nxt_out_s = idle_out(out_r.addr);
                if (status_s != ST_PASSIVE) begin
                    nxt_cyc_s        = status_s;
                    nxt_out_s.ale    = 1'b1;
                    nxt_out_s.addr   = bus.AD_IN;
                    nxt_out_s.dt_r_n = ~is_read(status_s);
                    nxt_state_s      = (status_s == ST_HALT) ? HLT : T1;
                end else begin
                    nxt_state_s = IDLE;
                end
            end
            T1: begin
                nxt_state_s   = T2;
                load_s        = 1'b1;
                load_val_s    = is_io(cyc_r) ? IO_WAIT_C : MEM_WAIT_C;
                nxt_out_s.den = 1'b1;
                case (cyc_r)
                    ST_INTA:          nxt_out_s.inta_n  = 1'b0;
                    ST_IOR:           nxt_out_s.iorc_n  = 1'b0;
                    ST_IOW:           nxt_out_s.aiowc_n = 1'b0;
                    ST_CODE, ST_MEMR: nxt_out_s.mrdc_n  = 1'b0;
                    ST_MEMW:          nxt_out_s.amwc_n  = 1'b0;
                    default:          nxt_out_s.den     = 1'b0;
                endcase
            end
            T2: begin
                nxt_state_s = TW;
                case (cyc_r)
                    ST_IOW:  nxt_out_s.iowc_n = 1'b0;
                    ST_MEMW: nxt_out_s.mwtc_n = 1'b0;
                    default: nxt_out_s.den    = out_r.den;
                endcase
            end
            TW: begin
                if (ready_s) begin
                    nxt_state_s = T4;
                    nxt_out_s   = idle_out(out_r.addr);
                end else begin
                    nxt_state_s = TW;
                end
            end
            HLT: begin
                nxt_out_s = idle_out(out_r.addr);
                if (status_s == ST_PASSIVE) begin
                    nxt_state_s = IDLE;
                end else begin
                    nxt_state_s = HLT;
                end
            end
            default: begin
                nxt_state_s = IDLE;
                nxt_out_s   = idle_out(out_r.addr);
            end
        endcase
        nxt_out_s.busy = (nxt_state_s != IDLE);
    end

    // State, latched cycle type and registered bus outputs
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r <= IDLE;
            cyc_r   <= ST_PASSIVE;
            out_r   <= idle_out(20'h00000);
        end else begin
            state_r <= nxt_state_s;
            cyc_r   <= nxt_cyc_s;
            out_r   <= nxt_out_s;
        end
    end

    assign bus.ADDR      = out_r.addr;
    assign bus.ALE       = out_r.ale;
    assign bus.MRDC_N    = out_r.mrdc_n;
    assign bus.MWTC_N    = out_r.mwtc_n;
    assign bus.AMWC_N    = out_r.amwc_n;
    assign bus.IORC_N    = out_r.iorc_n;
    assign bus.IOWC_N    = out_r.iowc_n;
    assign bus.AIOWC_N   = out_r.aiowc_n;
    assign bus.INTA_N    = out_r.inta_n;
    assign bus.DT_R_N    = out_r.dt_r_n;
    assign bus.DEN       = out_r.den;
    assign bus.BUSY      = out_r.busy;
    assign bus.READY_OUT = ready_s;

endmodule
